// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the command arbiter and its neighbours.
// Holds the arbiter state encoding, the device reply codes and the host
// command bytes used at runtime.
package ps2_pkg;

    // Link ownership phases of the command arbiter.
    typedef enum logic [2:0] {
        StMOwn    = 3'd0,
        StHSend   = 3'd1,
        StHTxWait = 3'd2,
        StHResp   = 3'd3,
        StHFin    = 3'd4
    } arb_state_e;

    // Device replies
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // Host commands
    localparam logic [7:0] PS2_CMD_GET_ID      = 8'hF2;
    localparam logic [7:0] PS2_CMD_SET_RATE    = 8'hF3;
    localparam logic [7:0] PS2_CMD_ENABLE_RPT  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET       = 8'hFF;

    function automatic logic ps2_is_ack(input logic [7:0] b);
        return b == PS2_ACK;
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Saturating timeout counter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear to zero (wins over enable)
//   enable    - count up by one per cycle, holding at all-ones
//   expired   - count has reached LIMIT
module ps2_timeout_ctr #(
    parameter int unsigned CTR_W = 24,
    parameter int unsigned LIMIT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CTR_W-1:0] LimitVal = CTR_W'(LIMIT);
    localparam logic [CTR_W-1:0] MaxVal   = '1;

    logic [CTR_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != MaxVal)) begin
            count_q <= count_q + CTR_W'(1);
        end
    end

    assign expired = (count_q >= LimitVal);

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares one PS/2 transmitter/receiver pair between the mouse master (M,
// default owner) and a host command port (H). H is granted only at a master
// packet boundary; the arbiter sends H's byte, collects up to three response
// bytes, then hands the link back to M.
// Ports:
//   CLK, RESET                    - clock, asynchronous active-high reset
//   M_*                           - master side (send, receive, idle status)
//   H_REQ/H_CMD/H_RESP_LEN        - host request, command byte, reply length
//   H_BUSY/H_RESP_*/H_DONE/H_ERROR- host transaction status and reply bytes
//   SEND_BYTE/BYTE_TO_SEND/...    - transceiver side
//   OWNER                         - 0 = master, 1 = host
module ps2_cmd_arbiter
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned CTR_W          = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       M_SEND_BYTE,
    input  logic [7:0] M_BYTE_TO_SEND,
    output logic       M_BYTE_SENT,
    input  logic       M_READ_ENABLE,
    output logic       M_BYTE_READY,
    input  logic       M_IDLE,
    input  logic       H_REQ,
    input  logic [7:0] H_CMD,
    input  logic [1:0] H_RESP_LEN,
    output logic       H_BUSY,
    output logic [7:0] H_RESP_DATA,
    output logic       H_RESP_VALID,
    output logic       H_DONE,
    output logic       H_ERROR,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic       OWNER
);

    arb_state_e state_q;
    logic [7:0] cmd_q;
    logic [1:0] len_q;
    logic [1:0] idx_q;
    logic       m_tx_pend_q;
    logic       m_replay_q;
    logic [7:0] replay_byte_q;

    logic m_send;
    logic grant;
    logic rx_bad;
    logic rx_last;
    logic fin_now;
    logic fin_err;
    logic ctr_expired;

    ps2_timeout_ctr #(
        .CTR_W (CTR_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (state_q == StHSend),
        .enable  ((state_q == StHTxWait) || (state_q == StHResp)),
        .expired (ctr_expired)
    );

    // A send the master issued while H owned the link is replayed on return.
    assign m_send = M_SEND_BYTE | m_replay_q;

    assign grant = (state_q == StMOwn) & H_REQ & M_IDLE & ~m_send & ~m_tx_pend_q & ~BYTE_READY;

    assign rx_bad  = (BYTE_ERROR_CODE != 2'b00) || ((idx_q == 2'd0) && !ps2_is_ack(BYTE_READ));
    assign rx_last = ((idx_q + 2'd1) == len_q);

    // Transceiver routing
    always_comb begin
        SEND_BYTE    = 1'b0;
        BYTE_TO_SEND = cmd_q;
        READ_ENABLE  = 1'b0;
        M_BYTE_SENT  = 1'b0;
        M_BYTE_READY = 1'b0;
        if (state_q == StMOwn) begin
            SEND_BYTE    = m_send;
            BYTE_TO_SEND = m_replay_q ? replay_byte_q : M_BYTE_TO_SEND;
            READ_ENABLE  = M_READ_ENABLE;
            M_BYTE_SENT  = BYTE_SENT;
            M_BYTE_READY = BYTE_READY;
        end else begin
            SEND_BYTE   = (state_q == StHSend);
            READ_ENABLE = (state_q == StHResp);
        end
    end

    // Transaction end detection; a link event in the same cycle as expiry wins.
    always_comb begin
        fin_now = 1'b0;
        fin_err = 1'b0;
        unique case (state_q)
            StHTxWait: begin
                if (BYTE_SENT) begin
                    fin_now = (len_q == 2'd0);
                end else if (ctr_expired) begin
                    fin_now = 1'b1;
                    fin_err = 1'b1;
                end
            end
            StHResp: begin
                if (BYTE_READY) begin
                    fin_now = rx_bad | rx_last;
                    fin_err = rx_bad;
                end else if (ctr_expired) begin
                    fin_now = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StMOwn;
            cmd_q         <= 8'hFF;
            len_q         <= 2'd0;
            idx_q         <= 2'd0;
            m_tx_pend_q   <= 1'b0;
            m_replay_q    <= 1'b0;
            replay_byte_q <= 8'h00;
            H_BUSY        <= 1'b0;
            H_RESP_DATA   <= 8'h00;
            H_RESP_VALID  <= 1'b0;
            H_DONE        <= 1'b0;
            H_ERROR       <= 1'b0;
            OWNER         <= 1'b0;
        end else begin
            H_RESP_VALID <= 1'b0;
            H_DONE       <= 1'b0;
            H_ERROR      <= 1'b0;

            if ((state_q != StMOwn) && M_SEND_BYTE) begin
                m_replay_q    <= 1'b1;
                replay_byte_q <= M_BYTE_TO_SEND;
            end

            if (fin_now) begin
                state_q <= StHFin;
                H_DONE  <= 1'b1;
                H_ERROR <= fin_err;
                H_BUSY  <= 1'b0;
            end

            unique case (state_q)
                StMOwn: begin
                    m_replay_q <= 1'b0;
                    if (m_send) begin
                        m_tx_pend_q <= 1'b1;
                    end else if (BYTE_SENT) begin
                        m_tx_pend_q <= 1'b0;
                    end
                    if (grant) begin
                        cmd_q   <= H_CMD;
                        len_q   <= H_RESP_LEN;
                        H_BUSY  <= 1'b1;
                        OWNER   <= 1'b1;
                        state_q <= StHSend;
                    end
                end
                StHSend: begin
                    idx_q   <= 2'd0;
                    state_q <= StHTxWait;
                end
                StHTxWait: begin
                    if (BYTE_SENT && (len_q != 2'd0)) begin
                        state_q <= StHResp;
                    end
                end
                StHResp: begin
                    if (BYTE_READY) begin
                        H_RESP_DATA  <= BYTE_READ;
                        H_RESP_VALID <= 1'b1;
                        if (!fin_now) begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                StHFin: begin
                    OWNER   <= 1'b0;
                    state_q <= StMOwn;
                end
                default: state_q <= StMOwn;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Randomized and directed bench for ps2_cmd_arbiter against a
// transaction-level model of the link-sharing rules.
module tb_ps2_cmd_arbiter;

    localparam int TO = 100;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       M_SEND_BYTE = 1'b0;
    logic [7:0] M_BYTE_TO_SEND = 8'h00;
    logic       M_BYTE_SENT;
    logic       M_READ_ENABLE = 1'b0;
    logic       M_BYTE_READY;
    logic       M_IDLE = 1'b1;
    logic       H_REQ = 1'b0;
    logic [7:0] H_CMD = 8'h00;
    logic [1:0] H_RESP_LEN = 2'd0;
    logic       H_BUSY;
    logic [7:0] H_RESP_DATA;
    logic       H_RESP_VALID;
    logic       H_DONE;
    logic       H_ERROR;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic       OWNER;

    ps2_cmd_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .CTR_W          (24)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .M_SEND_BYTE     (M_SEND_BYTE),
        .M_BYTE_TO_SEND  (M_BYTE_TO_SEND),
        .M_BYTE_SENT     (M_BYTE_SENT),
        .M_READ_ENABLE   (M_READ_ENABLE),
        .M_BYTE_READY    (M_BYTE_READY),
        .M_IDLE          (M_IDLE),
        .H_REQ           (H_REQ),
        .H_CMD           (H_CMD),
        .H_RESP_LEN      (H_RESP_LEN),
        .H_BUSY          (H_BUSY),
        .H_RESP_DATA     (H_RESP_DATA),
        .H_RESP_VALID    (H_RESP_VALID),
        .H_DONE          (H_DONE),
        .H_ERROR         (H_ERROR),
        .SEND_BYTE       (SEND_BYTE),
        .BYTE_TO_SEND    (BYTE_TO_SEND),
        .BYTE_SENT       (BYTE_SENT),
        .READ_ENABLE     (READ_ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY),
        .OWNER           (OWNER)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Model: who owns the link, and for a host transaction how far it got.
    bit         mh = 0;        // host owns the link
    bit         mfin = 0;      // host transaction in its final (done) cycle
    bit         merr = 0;
    bit         mrep = 0;      // master send waiting to be replayed
    logic [7:0] mrbyte = 8'h00;
    bit         mpend = 0;     // master byte in flight
    logic [7:0] mcmd = 8'hFF;
    int         mlen = 0;
    int         hcyc = 0;      // cycles since host took the link
    bit         txd = 0;       // host command byte has been sent
    int         nrx = 0;       // response bytes accepted
    bit         mrv = 0;
    logic [7:0] mrdata = 8'h00;

    logic       e_send, e_ren, e_msent, e_mready;
    logic [7:0] e_tbyte;
    bit         grant_m, rv_n;
    int         age;

    always @(negedge CLK) begin
        if (chk_en) begin
            if (RESET) begin
                mh = 0; mfin = 0; merr = 0; mrep = 0; mrbyte = 8'h00; mpend = 0;
                mcmd = 8'hFF; mlen = 0; hcyc = 0; txd = 0; nrx = 0; mrv = 0; mrdata = 8'h00;
            end
            if (!mh) begin
                e_send   = mrep ? 1'b1 : M_SEND_BYTE;
                e_tbyte  = mrep ? mrbyte : M_BYTE_TO_SEND;
                e_ren    = M_READ_ENABLE;
                e_msent  = BYTE_SENT;
                e_mready = BYTE_READY;
            end else begin
                e_send   = (hcyc == 0);
                e_tbyte  = mcmd;
                e_ren    = txd && !mfin;
                e_msent  = 1'b0;
                e_mready = 1'b0;
            end
            check("SEND_BYTE", {7'd0, SEND_BYTE}, {7'd0, e_send});
            check("BYTE_TO_SEND", BYTE_TO_SEND, e_tbyte);
            check("READ_ENABLE", {7'd0, READ_ENABLE}, {7'd0, e_ren});
            check("M_BYTE_SENT", {7'd0, M_BYTE_SENT}, {7'd0, e_msent});
            check("M_BYTE_READY", {7'd0, M_BYTE_READY}, {7'd0, e_mready});
            check("H_BUSY", {7'd0, H_BUSY}, {7'd0, mh && !mfin});
            check("OWNER", {7'd0, OWNER}, {7'd0, mh});
            check("H_DONE", {7'd0, H_DONE}, {7'd0, mfin});
            check("H_ERROR", {7'd0, H_ERROR}, {7'd0, mfin && merr});
            check("H_RESP_VALID", {7'd0, H_RESP_VALID}, {7'd0, mrv});
            check("H_RESP_DATA", H_RESP_DATA, mrdata);

            if (!RESET) begin
                rv_n = 0;
                if (!mh) begin
                    grant_m = H_REQ && M_IDLE && !e_send && !mpend && !BYTE_READY;
                    if (e_send) mpend = 1;
                    else if (BYTE_SENT) mpend = 0;
                    mrep = 0;
                    if (grant_m) begin
                        mh = 1; mfin = 0; hcyc = 0; txd = 0; nrx = 0;
                        mcmd = H_CMD; mlen = int'(H_RESP_LEN);
                    end
                end else begin
                    if (M_SEND_BYTE) begin
                        mrep = 1;
                        mrbyte = M_BYTE_TO_SEND;
                    end
                    if (mfin) begin
                        mh = 0;
                        mfin = 0;
                    end else if (hcyc > 0) begin
                        age = hcyc - 1;
                        if (!txd) begin
                            if (BYTE_SENT) begin
                                if (mlen == 0) begin mfin = 1; merr = 0; end
                                else txd = 1;
                            end else if (age >= TO) begin
                                mfin = 1; merr = 1;
                            end
                        end else if (BYTE_READY) begin
                            rv_n = 1;
                            mrdata = BYTE_READ;
                            if (BYTE_ERROR_CODE != 2'b00 || (nrx == 0 && BYTE_READ != 8'hFA)) begin
                                mfin = 1; merr = 1;
                            end else begin
                                nrx++;
                                if (nrx == mlen) begin mfin = 1; merr = 0; end
                            end
                        end else if (age >= TO) begin
                            mfin = 1; merr = 1;
                        end
                    end
                    hcyc++;
                end
                mrv = rv_n;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic obs();
        @(negedge CLK);
    endtask

    // Raise H_REQ and stop at the first cycle the host owns the link.
    task automatic host_start(input logic [7:0] cmd, input logic [1:0] len);
        int n;
        step();
        M_IDLE = 1'b1; H_REQ = 1'b1; H_CMD = cmd; H_RESP_LEN = len;
        obs();
        n = 0;
        while (H_BUSY !== 1'b1 && n < 20) begin
            step();
            obs();
            n++;
        end
        check("grant_wait", {7'd0, H_BUSY}, 8'd1);
    endtask

    task automatic sent();
        step(); BYTE_SENT = 1'b1; obs();
        step(); BYTE_SENT = 1'b0; obs();
    endtask

    task automatic resp(input logic [7:0] b, input logic [1:0] code);
        step(); BYTE_READY = 1'b1; BYTE_READ = b; BYTE_ERROR_CODE = code; obs();
        step(); BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00; obs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit quiet;
        #1;
        RESET = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        obs();
        check("rst_busy", {7'd0, H_BUSY}, 8'd0);
        check("rst_owner", {7'd0, OWNER}, 8'd0);
        check("rst_resp_data", H_RESP_DATA, 8'h00);
        check("rst_done", {7'd0, H_DONE}, 8'd0);
        step(); RESET = 1'b0; obs();

        // Master pass-through
        step(); M_SEND_BYTE = 1'b1; M_BYTE_TO_SEND = 8'hF4; obs();
        check("pt_send", {7'd0, SEND_BYTE}, 8'd1);
        check("pt_byte", BYTE_TO_SEND, 8'hF4);
        step(); M_SEND_BYTE = 1'b0; BYTE_SENT = 1'b1; obs();
        check("pt_sent", {7'd0, M_BYTE_SENT}, 8'd1);
        check("pt_owner", {7'd0, OWNER}, 8'd0);
        step(); BYTE_SENT = 1'b0; obs();

        // F3, one-byte reply
        host_start(8'hF3, 2'd1);
        check("f3_send", {7'd0, SEND_BYTE}, 8'd1);
        check("f3_byte", BYTE_TO_SEND, 8'hF3);
        check("f3_owner", {7'd0, OWNER}, 8'd1);
        step(); H_REQ = 1'b0; obs();
        check("f3_send_once", {7'd0, SEND_BYTE}, 8'd0);
        sent();
        step(); BYTE_READY = 1'b1; BYTE_READ = 8'hFA; obs();
        check("f3_ren", {7'd0, READ_ENABLE}, 8'd1);
        check("f3_mready_blocked", {7'd0, M_BYTE_READY}, 8'd0);
        step(); BYTE_READY = 1'b0; obs();
        check("f3_rv", {7'd0, H_RESP_VALID}, 8'd1);
        check("f3_data", H_RESP_DATA, 8'hFA);
        check("f3_done", {7'd0, H_DONE}, 8'd1);
        check("f3_err", {7'd0, H_ERROR}, 8'd0);
        step(); obs();
        check("f3_owner_back", {7'd0, OWNER}, 8'd0);

        // F2, two-byte reply, held off while master is mid-packet
        step(); M_IDLE = 1'b0; H_REQ = 1'b1; H_CMD = 8'hF2; H_RESP_LEN = 2'd2;
        repeat (5) begin step(); obs(); end
        check("f2_holdoff", {7'd0, H_BUSY}, 8'd0);
        host_start(8'hF2, 2'd2);
        step(); H_REQ = 1'b0; obs();
        sent();
        resp(8'hFA, 2'b00);
        check("f2_rv0", {7'd0, H_RESP_VALID}, 8'd1);
        check("f2_data0", H_RESP_DATA, 8'hFA);
        check("f2_notdone", {7'd0, H_DONE}, 8'd0);
        resp(8'h03, 2'b00);
        check("f2_data1", H_RESP_DATA, 8'h03);
        check("f2_done", {7'd0, H_DONE}, 8'd1);
        check("f2_err", {7'd0, H_ERROR}, 8'd0);

        // Bad ack, then receiver error code
        host_start(8'hFF, 2'd3);
        step(); H_REQ = 1'b0; obs();
        sent();
        resp(8'hFE, 2'b00);
        check("nak_data", H_RESP_DATA, 8'hFE);
        check("nak_done", {7'd0, H_DONE}, 8'd1);
        check("nak_err", {7'd0, H_ERROR}, 8'd1);
        step(); obs();
        check("nak_owner", {7'd0, OWNER}, 8'd0);
        host_start(8'hF3, 2'd1);
        step(); H_REQ = 1'b0; obs();
        sent();
        resp(8'hFA, 2'b01);
        check("code_done", {7'd0, H_DONE}, 8'd1);
        check("code_err", {7'd0, H_ERROR}, 8'd1);

        // Timeout: no reply after the command byte
        host_start(8'hF4, 2'd1);
        n = 0;
        step(); H_REQ = 1'b0; BYTE_SENT = 1'b1; obs(); n++;
        step(); BYTE_SENT = 1'b0; obs(); n++;
        while (H_DONE !== 1'b1 && n < 300) begin
            step(); obs(); n++;
        end
        check("to_latency", 8'(n), 8'd102);
        check("to_err", {7'd0, H_ERROR}, 8'd1);

        // Reset in the middle of a reply
        host_start(8'hF2, 2'd2);
        step(); H_REQ = 1'b0; obs();
        sent();
        resp(8'hFA, 2'b00);
        step(); RESET = 1'b1; obs();
        check("mrst_owner", {7'd0, OWNER}, 8'd0);
        check("mrst_busy", {7'd0, H_BUSY}, 8'd0);
        check("mrst_data", H_RESP_DATA, 8'h00);
        check("mrst_rv", {7'd0, H_RESP_VALID}, 8'd0);
        step(); RESET = 1'b0; obs();
        check("mrst_nodone", {7'd0, H_DONE}, 8'd0);

        // Master send during host ownership is replayed afterwards
        host_start(8'hF4, 2'd1);
        step(); H_REQ = 1'b0; M_SEND_BYTE = 1'b1; M_BYTE_TO_SEND = 8'hFF; obs();
        check("rep_blocked", {7'd0, SEND_BYTE}, 8'd0);
        step(); M_SEND_BYTE = 1'b0; M_BYTE_TO_SEND = 8'h00; obs();
        sent();
        resp(8'hFA, 2'b00);
        check("rep_done", {7'd0, H_DONE}, 8'd1);
        step(); obs();
        check("rep_send", {7'd0, SEND_BYTE}, 8'd1);
        check("rep_byte", BYTE_TO_SEND, 8'hFF);
        step(); obs();
        check("rep_once", {7'd0, SEND_BYTE}, 8'd0);
        sent();

        // Random traffic; periodic quiet windows let timeouts fire
        for (int i = 0; i < 4000; i++) begin
            step();
            quiet = (i % 1000) > 800;
            RESET = ($urandom_range(0, 499) == 0);
            M_SEND_BYTE = ($urandom_range(0, 11) == 0);
            M_BYTE_TO_SEND = 8'($urandom);
            M_READ_ENABLE = 1'($urandom);
            M_IDLE = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) H_REQ = ~H_REQ;
            H_CMD = 8'($urandom);
            H_RESP_LEN = 2'($urandom);
            BYTE_SENT = !quiet && ($urandom_range(0, 5) == 0);
            BYTE_READY = !quiet && ($urandom_range(0, 5) == 0);
            BYTE_READ = ($urandom_range(0, 9) < 7) ? 8'hFA : 8'($urandom);
            BYTE_ERROR_CODE = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
        end
        step();
        RESET = 1'b0; M_SEND_BYTE = 1'b0; H_REQ = 1'b0; BYTE_SENT = 1'b0; BYTE_READY = 1'b0;
        repeat (5) begin step(); obs(); end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
